// File: rtl/mig_burst_scheduler.sv
// +--------------------------------------------------------------------------+
// | mig_burst_scheduler: picks direction/address/length of the next DDR      |
// | burst for the MIG-backed FIFO and tracks DDR ring occupancy.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mig_burst_scheduler #(
  parameter int          MAX_BURST_LEN  = 64,
  parameter int          RW_DELAY_VALUE = 4,
  parameter logic [31:0] BASE_ADDRESS   = 32'h0000_0000,
  parameter int          MEMORY_SIZE    = 100,
  parameter int          MIG_PORT_SIZE  = 128,
  parameter int          IO_FIFO_DEPTH  = 32
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        soft_resetn,
  input  logic        init_calib,
  input  logic [31:0] in_wr_count,
  input  logic [31:0] out_rd_count,
  output logic        wr_cmd_valid,
  input  logic        wr_cmd_ready,
  output logic [31:0] wr_cmd_addr,
  output logic [7:0]  wr_cmd_len,
  input  logic        wr_done,
  output logic        rd_cmd_valid,
  input  logic        rd_cmd_ready,
  output logic [31:0] rd_cmd_addr,
  output logic [7:0]  rd_cmd_len,
  input  logic        rd_done,
  output logic [31:0] mem_count,
  output logic        mem_full,
  output logic        mem_empty
);

  localparam int          c_bpw        = MIG_PORT_SIZE / 8;
  localparam int          c_bpw_log2   = $clog2(c_bpw);
  localparam logic [31:0] c_mem_size   = 32'(MEMORY_SIZE);
  localparam logic [31:0] c_max_burst  = 32'(MAX_BURST_LEN);
  localparam logic [31:0] c_fifo_depth = 32'(IO_FIFO_DEPTH);
  localparam logic [31:0] c_delay_m1   = (RW_DELAY_VALUE > 0) ? 32'(RW_DELAY_VALUE - 1) : 32'd0;

  localparam logic [2:0] c_st_cal      = 3'd0;
  localparam logic [2:0] c_st_idle     = 3'd1;
  localparam logic [2:0] c_st_wr_issue = 3'd2;
  localparam logic [2:0] c_st_wr_wait  = 3'd3;
  localparam logic [2:0] c_st_rd_issue = 3'd4;
  localparam logic [2:0] c_st_rd_wait  = 3'd5;
  localparam logic [2:0] c_st_turn     = 3'd6;

  localparam logic c_dir_rd = 1'b0;
  localparam logic c_dir_wr = 1'b1;

  logic [2:0]  r_state, w_state_nxt;
  logic [31:0] r_wr_ptr, r_rd_ptr, r_mem_count, r_beats, r_delay_cnt;
  logic [31:0] r_wr_addr, r_rd_addr;
  logic [7:0]  r_wr_len, r_rd_len;
  logic        r_mem_full, r_mem_empty, r_last_dir, r_flush_pending;

  logic [31:0] w_free, w_ofree;
  logic [31:0] w_wr_addr, w_rd_addr, w_wr_to4k, w_rd_to4k, w_wr_beats, w_rd_beats;
  logic        w_wr_ok, w_rd_ok, w_pick_wr, w_pick_rd;
  logic        w_wr_done_ev, w_rd_done_ev, w_flush, w_clear, w_in_burst;
  logic [31:0] w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt, w_wr_sum, w_rd_sum;

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  // Burst sizing: the shortest of data available, space, ring end and 4 KB line.
  always_comb begin
    w_free     = c_mem_size - r_mem_count;
    w_ofree    = (out_rd_count >= c_fifo_depth) ? 32'd0 : (c_fifo_depth - out_rd_count);
    w_wr_addr  = BASE_ADDRESS + (r_wr_ptr << c_bpw_log2);
    w_rd_addr  = BASE_ADDRESS + (r_rd_ptr << c_bpw_log2);
    w_wr_to4k  = (32'd4096 - {20'd0, w_wr_addr[11:0]}) >> c_bpw_log2;
    w_rd_to4k  = (32'd4096 - {20'd0, w_rd_addr[11:0]}) >> c_bpw_log2;
    w_wr_beats = min32(min32(min32(in_wr_count, c_max_burst),
                             min32(w_free, c_mem_size - r_wr_ptr)), w_wr_to4k);
    w_rd_beats = min32(min32(min32(r_mem_count, c_max_burst),
                             min32(w_ofree, c_mem_size - r_rd_ptr)), w_rd_to4k);
    w_wr_ok    = (in_wr_count != 32'd0) && (w_free != 32'd0);
    w_rd_ok    = (r_mem_count != 32'd0) && (w_ofree != 32'd0);
    w_pick_wr  = soft_resetn && w_wr_ok && (!w_rd_ok || (r_last_dir == c_dir_rd));
    w_pick_rd  = soft_resetn && w_rd_ok && !w_pick_wr;
  end

  always_comb begin
    w_wr_done_ev = (r_state == c_st_wr_wait) && wr_done;
    w_rd_done_ev = (r_state == c_st_rd_wait) && rd_done;
    w_flush      = r_flush_pending || !soft_resetn;
    w_in_burst   = (r_state == c_st_wr_issue) || (r_state == c_st_wr_wait) ||
                   (r_state == c_st_rd_issue) || (r_state == c_st_rd_wait);
    w_clear      = (!w_in_burst && (r_state != c_st_turn || 1'b1) && !soft_resetn &&
                    ((r_state == c_st_cal) || (r_state == c_st_idle) || (r_state == c_st_turn))) ||
                   ((w_wr_done_ev || w_rd_done_ev) && w_flush);
    w_wr_sum     = r_wr_ptr + r_beats;
    w_rd_sum     = r_rd_ptr + r_beats;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_mem_count;
    if (w_clear) begin
      w_wr_ptr_nxt = 32'd0;
      w_rd_ptr_nxt = 32'd0;
      w_count_nxt  = 32'd0;
    end else if (w_wr_done_ev) begin
      w_wr_ptr_nxt = (w_wr_sum >= c_mem_size) ? 32'd0 : w_wr_sum;
      w_count_nxt  = min32(r_mem_count + r_beats, c_mem_size);
    end else if (w_rd_done_ev) begin
      w_rd_ptr_nxt = (w_rd_sum >= c_mem_size) ? 32'd0 : w_rd_sum;
      w_count_nxt  = (r_mem_count >= r_beats) ? (r_mem_count - r_beats) : 32'd0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= c_st_cal;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_cal:      if (init_calib) w_state_nxt = c_st_idle;
      c_st_idle: begin
        if (w_pick_wr)      w_state_nxt = c_st_wr_issue;
        else if (w_pick_rd) w_state_nxt = c_st_rd_issue;
      end
      c_st_wr_issue: if (wr_cmd_ready) w_state_nxt = c_st_wr_wait;
      c_st_rd_issue: if (rd_cmd_ready) w_state_nxt = c_st_rd_wait;
      c_st_wr_wait, c_st_rd_wait: begin
        // A flushed burst skips the turnaround and returns straight to IDLE.
        if (w_wr_done_ev || w_rd_done_ev)
          w_state_nxt = (w_flush || RW_DELAY_VALUE == 0) ? c_st_idle : c_st_turn;
      end
      c_st_turn:     if (r_delay_cnt == 32'd0) w_state_nxt = c_st_idle;
      default:       w_state_nxt = c_st_cal;
    endcase
  end

  always_comb begin
    wr_cmd_valid = (r_state == c_st_wr_issue);
    rd_cmd_valid = (r_state == c_st_rd_issue);
    wr_cmd_addr  = r_wr_addr;
    wr_cmd_len   = r_wr_len;
    rd_cmd_addr  = r_rd_addr;
    rd_cmd_len   = r_rd_len;
    mem_count    = r_mem_count;
    mem_full     = r_mem_full;
    mem_empty    = r_mem_empty;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_ptr        <= 32'd0;
      r_rd_ptr        <= 32'd0;
      r_mem_count     <= 32'd0;
      r_mem_full      <= 1'b0;
      r_mem_empty     <= 1'b1;
      r_beats         <= 32'd0;
      r_delay_cnt     <= 32'd0;
      r_wr_addr       <= 32'd0;
      r_rd_addr       <= 32'd0;
      r_wr_len        <= 8'd0;
      r_rd_len        <= 8'd0;
      r_last_dir      <= c_dir_rd;
      r_flush_pending <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_mem_count <= w_count_nxt;
      r_mem_full  <= (w_count_nxt == c_mem_size);
      r_mem_empty <= (w_count_nxt == 32'd0);
      if (r_state == c_st_idle) begin
        if (w_pick_wr) begin
          r_wr_addr  <= w_wr_addr;
          r_wr_len   <= 8'(w_wr_beats - 32'd1);
          r_beats    <= w_wr_beats;
          r_last_dir <= c_dir_wr;
        end else if (w_pick_rd) begin
          r_rd_addr  <= w_rd_addr;
          r_rd_len   <= 8'(w_rd_beats - 32'd1);
          r_beats    <= w_rd_beats;
          r_last_dir <= c_dir_rd;
        end
      end
      if (w_wr_done_ev || w_rd_done_ev) begin
        r_delay_cnt     <= c_delay_m1;
        r_flush_pending <= 1'b0;
      end else begin
        if (r_state == c_st_turn && r_delay_cnt != 32'd0)
          r_delay_cnt <= r_delay_cnt - 32'd1;
        if (w_in_burst && !soft_resetn)
          r_flush_pending <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mig_burst_scheduler.sv
// +--------------------------------------------------------------------------+
// | tb_mig_burst_scheduler: directed self-checking bench for the scheduler.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mig_burst_scheduler;

  logic        aclk = 1'b0;
  logic        aresetn, soft_resetn, init_calib;
  logic [31:0] in_wr_count, out_rd_count;
  logic        wr_cmd_valid, wr_cmd_ready, wr_done;
  logic [31:0] wr_cmd_addr;
  logic [7:0]  wr_cmd_len;
  logic        rd_cmd_valid, rd_cmd_ready, rd_done;
  logic [31:0] rd_cmd_addr;
  logic [7:0]  rd_cmd_len;
  logic [31:0] mem_count;
  logic        mem_full, mem_empty;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  mig_burst_scheduler #(
    .MAX_BURST_LEN (64),
    .RW_DELAY_VALUE(4),
    .BASE_ADDRESS  (32'h0000_0000),
    .MEMORY_SIZE   (100),
    .MIG_PORT_SIZE (128),
    .IO_FIFO_DEPTH (32)
  ) u_dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .soft_resetn (soft_resetn),
    .init_calib  (init_calib),
    .in_wr_count (in_wr_count),
    .out_rd_count(out_rd_count),
    .wr_cmd_valid(wr_cmd_valid),
    .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr (wr_cmd_addr),
    .wr_cmd_len  (wr_cmd_len),
    .wr_done     (wr_done),
    .rd_cmd_valid(rd_cmd_valid),
    .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr (rd_cmd_addr),
    .rd_cmd_len  (rd_cmd_len),
    .rd_done     (rd_done),
    .mem_count   (mem_count),
    .mem_full    (mem_full),
    .mem_empty   (mem_empty)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Wait for a command, check it, optionally hold off ready, then accept it.
  task automatic do_issue(input bit exp_wr, input logic [31:0] exp_addr,
                          input logic [7:0] exp_len, input int hold, input int exp_wait);
    int          waited;
    bit          stable;
    logic [31:0] a;
    logic [7:0]  l;
    waited = 0;
    stable = 1'b1;
    while (!(wr_cmd_valid || rd_cmd_valid) && waited < 300) begin
      @(negedge aclk);
      waited++;
    end
    chk("cmd_seen", 32'(wr_cmd_valid || rd_cmd_valid), 32'd1);
    if (exp_wait >= 0) chk("cmd_spacing", 32'(waited), 32'(exp_wait));
    chk("cmd_dir_wr", 32'(wr_cmd_valid), 32'(exp_wr));
    a = exp_wr ? wr_cmd_addr : rd_cmd_addr;
    l = exp_wr ? wr_cmd_len  : rd_cmd_len;
    chk("cmd_addr", a, exp_addr);
    chk("cmd_len", 32'(l), 32'(exp_len));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge aclk);
        if (exp_wr) begin
          if (!wr_cmd_valid || wr_cmd_addr != a || wr_cmd_len != l) stable = 1'b0;
        end else begin
          if (!rd_cmd_valid || rd_cmd_addr != a || rd_cmd_len != l) stable = 1'b0;
        end
      end
      chk("hold_stable", 32'(stable), 32'd1);
    end
    if (exp_wr) wr_cmd_ready = 1'b1;
    else        rd_cmd_ready = 1'b1;
    @(negedge aclk);
    wr_cmd_ready = 1'b0;
    rd_cmd_ready = 1'b0;
    chk("valid_drop", 32'(wr_cmd_valid || rd_cmd_valid), 32'd0);
  endtask

  task automatic do_done(input bit is_wr, input int beats);
    repeat (3) @(negedge aclk);
    if (is_wr) wr_done = 1'b1;
    else       rd_done = 1'b1;
    @(negedge aclk);
    wr_done = 1'b0;
    rd_done = 1'b0;
    if (is_wr) in_wr_count = in_wr_count - 32'(beats);
  endtask

  task automatic do_reset();
    aresetn      = 1'b0;
    wr_cmd_ready = 1'b0;
    rd_cmd_ready = 1'b0;
    wr_done      = 1'b0;
    rd_done      = 1'b0;
    in_wr_count  = 32'd0;
    out_rd_count = 32'd32;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge aclk);
      if (wr_cmd_valid || rd_cmd_valid) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    soft_resetn = 1'b1;
    init_calib  = 1'b0;
    do_reset();
    aresetn = 1'b0;
    @(negedge aclk);
    chk("rst_wr_valid", 32'(wr_cmd_valid), 32'd0);
    chk("rst_rd_valid", 32'(rd_cmd_valid), 32'd0);
    chk("rst_wr_addr", wr_cmd_addr, 32'd0);
    chk("rst_wr_len", 32'(wr_cmd_len), 32'd0);
    chk("rst_rd_addr", rd_cmd_addr, 32'd0);
    chk("rst_rd_len", 32'(rd_cmd_len), 32'd0);
    chk("rst_mem_count", mem_count, 32'd0);
    chk("rst_mem_full", 32'(mem_full), 32'd0);
    chk("rst_mem_empty", 32'(mem_empty), 32'd1);
    aresetn = 1'b1;

    // Calibration gate, then first write two cycles after init_calib rises
    in_wr_count = 32'd10;
    expect_quiet("cal_no_cmd", 50);
    init_calib = 1'b1;
    @(negedge aclk);
    chk("cal_exit_c1", 32'(wr_cmd_valid), 32'd0);
    @(negedge aclk);
    chk("cal_exit_c2", 32'(wr_cmd_valid), 32'd1);
    do_issue(1'b1, 32'h000, 8'd9, 0, 0);
    do_done(1'b1, 10);
    chk("t1_mem_count", mem_count, 32'd10);

    // Ring wrap: write 70, read 70, write 50
    do_reset();
    in_wr_count = 32'd70;
    do_issue(1'b1, 32'h000, 8'd63, 0, -1);
    do_done(1'b1, 64);
    chk("t2_mem_64", mem_count, 32'd64);
    do_issue(1'b1, 32'h400, 8'd5, 0, 5);
    do_done(1'b1, 6);
    chk("t2_mem_70", mem_count, 32'd70);
    out_rd_count = 32'd0;
    do_issue(1'b0, 32'h000, 8'd31, 0, -1);
    do_done(1'b0, 32);
    do_issue(1'b0, 32'h200, 8'd31, 0, -1);
    do_done(1'b0, 32);
    do_issue(1'b0, 32'h400, 8'd5, 0, -1);
    do_done(1'b0, 6);
    chk("t2_mem_0", mem_count, 32'd0);
    chk("t2_empty", 32'(mem_empty), 32'd1);
    out_rd_count = 32'd32;
    in_wr_count  = 32'd50;
    do_issue(1'b1, 32'h460, 8'd29, 0, -1);
    do_done(1'b1, 30);
    do_issue(1'b1, 32'h000, 8'd19, 0, -1);
    do_done(1'b1, 20);
    chk("t2_mem_50", mem_count, 32'd50);
    in_wr_count = 32'd50;
    do_issue(1'b1, 32'h140, 8'd49, 0, -1);
    do_done(1'b1, 50);
    chk("t2_mem_100", mem_count, 32'd100);
    chk("t2_full", 32'(mem_full), 32'd1);
    in_wr_count = 32'd5;
    expect_quiet("t2_full_no_cmd", 20);

    // Alternation with output-FIFO limit, then stalled write command
    do_reset();
    in_wr_count = 32'd20;
    do_issue(1'b1, 32'h000, 8'd19, 0, -1);
    do_done(1'b1, 20);
    in_wr_count  = 32'd64;
    out_rd_count = 32'd30;
    do_issue(1'b0, 32'h000, 8'd1, 0, -1);
    do_done(1'b0, 2);
    do_issue(1'b1, 32'h140, 8'd63, 20, -1);
    do_done(1'b1, 64);
    chk("t3_mem_82", mem_count, 32'd82);

    // Soft reset during RD_WAIT
    do_issue(1'b0, 32'h020, 8'd1, 0, -1);
    soft_resetn = 1'b0;
    @(negedge aclk);
    soft_resetn = 1'b1;
    in_wr_count  = 32'd5;
    out_rd_count = 32'd32;
    expect_quiet("t5_await_done", 5);
    chk("t5_mem_before", mem_count, 32'd82);
    do_done(1'b0, 2);
    chk("t5_mem_cleared", mem_count, 32'd0);
    chk("t5_empty", 32'(mem_empty), 32'd1);
    do_issue(1'b1, 32'h000, 8'd4, 0, 1);
    do_done(1'b1, 5);

    // Hard reset during WR_WAIT, stray wr_done ignored
    in_wr_count = 32'd3;
    do_issue(1'b1, 32'h050, 8'd2, 0, 5);
    aresetn    = 1'b0;
    init_calib = 1'b0;
    @(negedge aclk);
    chk("t6_wr_valid", 32'(wr_cmd_valid), 32'd0);
    chk("t6_wr_addr", wr_cmd_addr, 32'd0);
    chk("t6_wr_len", 32'(wr_cmd_len), 32'd0);
    chk("t6_mem_count", mem_count, 32'd0);
    chk("t6_empty", 32'(mem_empty), 32'd1);
    aresetn = 1'b1;
    @(negedge aclk);
    wr_done = 1'b1;
    @(negedge aclk);
    wr_done = 1'b0;
    expect_quiet("t6_cal_no_cmd", 10);
    chk("t6_stray_mem", mem_count, 32'd0);
    init_calib = 1'b1;
    do_issue(1'b1, 32'h000, 8'd2, 0, 2);
    do_done(1'b1, 3);
    chk("t6_mem_3", mem_count, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
